// File: rtl/body_mem_arbiter.sv
// body_mem_arbiter: round-robin two-reader/one-writer arbiter for a dual-port body RAM with write-hazard stalls
module body_mem_arbiter #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 80,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic [ADDR_W-1:0] r0_addr,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic [ADDR_W-1:0] r1_addr,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   input  logic              w_req,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_gnt,
   output logic [ADDR_W-1:0] rdaddress,
   output logic [ADDR_W-1:0] wraddress,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   input  logic [DATA_W-1:0] q,
   output logic [15:0]       stall_cnt
);
   logic haz0, haz1, c0, c1, last, issue;
   logic [ADDR_W-1:0] last_addr;
   logic [RD_LAT-1:0] vld, pid;
   assign haz0 = w_req && r0_addr == w_addr;
   assign haz1 = w_req && r1_addr == w_addr;
   assign c0 = r0_req && !haz0;
   assign c1 = r1_req && !haz1;
   // last is 1 when port 1 won most recently, so port 0 wins the next contest
   assign r0_gnt = !reset && c0 && (!c1 || last);
   assign r1_gnt = !reset && c1 && (!c0 || !last);
   assign issue = r0_gnt || r1_gnt;
   assign rdaddress = reset ? '0 : r0_gnt ? r0_addr : r1_gnt ? r1_addr : last_addr;
   assign w_gnt = !reset;
   assign wren = w_req && !reset;
   assign wraddress = w_addr;
   assign data = w_data;
   assign r0_rvalid = !reset && vld[RD_LAT-1] && !pid[RD_LAT-1];
   assign r1_rvalid = !reset && vld[RD_LAT-1] && pid[RD_LAT-1];
   assign r0_rdata = q;
   assign r1_rdata = q;
   always_ff @(posedge clk) begin
      if (reset) begin
         last <= 1'b1;
         last_addr <= '0;
         stall_cnt <= '0;
         vld <= '0;
         pid <= '0;
      end else begin
         if (issue) begin
            last <= r1_gnt;
            last_addr <= rdaddress;
         end
         if (((r0_req && haz0) || (r1_req && haz1)) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         vld[0] <= issue;
         pid[0] <= r1_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            vld[i] <= vld[i-1];
            pid[i] <= pid[i-1];
         end
      end
   end
endmodule

// File: tb/tb_body_mem_arbiter.sv
// tb_body_mem_arbiter: directed and random checks of the arbiter against a queue-based reference model
module tb_body_mem_arbiter;
   localparam int AW = 15, DW = 80, LAT = 2;
   typedef struct {int due; bit port; logic [DW-1:0] d;} ret_t;
   logic clk = 0, reset = 1;
   logic r0_req = 0, r1_req = 0, w_req = 0;
   logic [AW-1:0] r0_addr = 0, r1_addr = 0, w_addr = 0;
   logic [DW-1:0] w_data = 0;
   logic r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, w_gnt, wren;
   logic [DW-1:0] r0_rdata, r1_rdata, data, q;
   logic [AW-1:0] rdaddress, wraddress;
   logic [15:0] stall_cnt;
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] smem [0:(1<<AW)-1];
   logic [DW-1:0] rp [LAT];
   bit ram_init = 0;
   int tests = 0, fails = 0, n = 0, stall = 0;
   bit prio = 0, eg0 = 0, eg1 = 0;
   ret_t pend[$];

   always #5 clk = ~clk;

   body_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
      .rdaddress(rdaddress), .wraddress(wraddress), .data(data), .wren(wren), .q(q),
      .stall_cnt(stall_cnt));

   function automatic logic [DW-1:0] init_val(int a);
      return a == 5 ? DW'(80'h1234) : {16'hC0DE, 32'(a), 32'(a * 7)};
   endfunction

   // behavioural RAM: write and read-sample on the same edge, q delayed LAT-1 further edges
   assign q = rp[LAT-1];
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < (1<<AW); i++) ram[i] <= init_val(i);
         ram_init <= 1;
      end else if (wren) ram[wraddress] <= data;
      rp[0] <= ram[rdaddress];
      for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
   end

   task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: entered at negedge with inputs applied, leaves at the next negedge
   task automatic cycle();
      bit e0, e1, blk, v0, v1;
      logic [DW-1:0] d0, d1;
      ret_t r;
      #1;
      if (reset) begin
         check("rst_r0_gnt", DW'(r0_gnt), 0);
         check("rst_r1_gnt", DW'(r1_gnt), 0);
         check("rst_w_gnt", DW'(w_gnt), 0);
         check("rst_wren", DW'(wren), 0);
         check("rst_r0_rvalid", DW'(r0_rvalid), 0);
         check("rst_r1_rvalid", DW'(r1_rvalid), 0);
         check("rst_rdaddress", DW'(rdaddress), 0);
         pend.delete();
         prio = 0;
         stall = 0;
         eg0 = 0;
         eg1 = 0;
      end else begin
         e0 = r0_req && !(w_req && r0_addr == w_addr);
         e1 = r1_req && !(w_req && r1_addr == w_addr);
         blk = (r0_req && !e0) || (r1_req && !e1);
         eg0 = e0 && (!e1 || !prio);
         eg1 = e1 && !eg0;
         v0 = 0; v1 = 0; d0 = '0; d1 = '0;
         while (pend.size() > 0 && pend[0].due == n) begin
            r = pend.pop_front();
            if (r.port) begin v1 = 1; d1 = r.d; end
            else begin v0 = 1; d0 = r.d; end
         end
         check("r0_gnt", DW'(r0_gnt), DW'(eg0));
         check("r1_gnt", DW'(r1_gnt), DW'(eg1));
         check("r0_rvalid", DW'(r0_rvalid), DW'(v0));
         check("r1_rvalid", DW'(r1_rvalid), DW'(v1));
         if (v0) check("r0_rdata", r0_rdata, d0);
         if (v1) check("r1_rdata", r1_rdata, d1);
         check("stall_cnt", DW'(stall_cnt), DW'(stall));
         check("w_gnt", DW'(w_gnt), 1);
         check("wren", DW'(wren), DW'(w_req));
         check("wraddress", DW'(wraddress), DW'(w_addr));
         check("data", data, w_data);
         if (eg0 || eg1) begin
            check("rdaddress", DW'(rdaddress), DW'(eg0 ? r0_addr : r1_addr));
            pend.push_back('{due: n + LAT, port: eg1, d: smem[eg0 ? r0_addr : r1_addr]});
            prio = eg0;
         end
         if (blk && stall < 65535) stall++;
         if (w_req) smem[w_addr] = w_data;
      end
      n++;
      @(negedge clk);
   endtask

   task automatic idle(int k);
      r0_req = 0; r1_req = 0; w_req = 0;
      for (int i = 0; i < k; i++) cycle();
   endtask

   task automatic do_reset(int k);
      reset = 1;
      for (int i = 0; i < k; i++) cycle();
      reset = 0;
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) smem[i] = init_val(i);
      @(negedge clk);
      idle(0);
      do_reset(3);
      // single read of addr 5, zero-wait grant, data after LAT cycles
      r0_req = 1; r0_addr = 5;
      cycle();
      r0_req = 0;
      idle(3);
      // contested stream alternates starting at port 0 after reset
      do_reset(1);
      r0_req = 1; r0_addr = 1; r1_req = 1; r1_addr = 2;
      for (int i = 0; i < 6; i++) cycle();
      idle(3);
      // read-after-write hazard stalls one cycle, then returns written data
      w_req = 1; w_addr = 3; w_data = DW'(80'hAB); r0_req = 1; r0_addr = 3;
      cycle();
      w_req = 0;
      cycle();
      idle(3);
      // hazard on port 0 lets port 1 through, port 0 follows next
      w_req = 1; w_addr = 7; w_data = DW'(80'h77); r0_req = 1; r0_addr = 7; r1_req = 1; r1_addr = 8;
      cycle();
      w_req = 0; r1_req = 0;
      cycle();
      idle(3);
      // reset with a read in flight drops its return
      r1_req = 1; r1_addr = 4;
      cycle();
      r1_req = 0;
      do_reset(1);
      r0_req = 1; r0_addr = 1; r1_req = 1; r1_addr = 2;
      cycle();
      idle(4);
      // random traffic; requesters hold until granted
      for (int i = 0; i < 400; i++) begin
         if (!r0_req || eg0) begin r0_req = 1'($urandom_range(0, 1)); r0_addr = AW'($urandom_range(0, 7)); end
         if (!r1_req || eg1) begin r1_req = 1'($urandom_range(0, 1)); r1_addr = AW'($urandom_range(0, 7)); end
         w_req = 1'($urandom_range(0, 1));
         w_addr = AW'($urandom_range(0, 7));
         w_data = DW'({$urandom, $urandom, $urandom});
         reset = ($urandom_range(0, 39) == 0);
         cycle();
      end
      reset = 0;
      idle(4);
      // sustained hazard saturates the stall counter
      do_reset(1);
      w_req = 1; w_addr = 9; w_data = DW'(80'h99); r0_req = 1; r0_addr = 9;
      for (int i = 0; i < 65540; i++) cycle();
      check("stall_sat", DW'(stall_cnt), DW'(16'hFFFF));
      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
